// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory request scheduler:
//   - WIDTH_DEF / PSIZE_DEF : default data / address widths
//   - wr_req_t              : write request layout {addr, data} at default widths
//   - gnt_e                 : arbitration grant {GNT_NONE, GNT_WR, GNT_RD}
//   - sat_inc               : saturating increment for the optional stats counters
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WIDTH_DEF = 2;
    localparam int PSIZE_DEF = 2;
    localparam int STAT_W    = 16;

    typedef struct packed {
        logic [PSIZE_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                   input logic              en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/mem_wr_fifo.sv
// -----------------------------------------------------------------------------
// mem_wr_fifo
// Write queue of WQ_DEPTH entries (power of two, >= 2). Besides the head it
// exposes a per-entry valid mask and address so the scheduler can detect
// read-after-write hazards against every queued write.
// Ports:
//   clk, rst_n             : clock, async active-low reset (empties queue)
//   push_i, push_addr_i,
//   push_data_i            : enqueue (ignored when full)
//   pop_i                  : dequeue head (ignored when empty)
//   full_o, empty_o        : occupancy flags
//   head_addr_o/head_data_o: oldest entry
//   ent_vld_o, ent_addr_o  : per-slot valid bit and address
// -----------------------------------------------------------------------------
module mem_wr_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PSIZE    = PSIZE_DEF,
    parameter int WQ_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push_i,
    input  logic [PSIZE-1:0]                   push_addr_i,
    input  logic [WIDTH-1:0]                   push_data_i,
    input  logic                               pop_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [PSIZE-1:0]                   head_addr_o,
    output logic [WIDTH-1:0]                   head_data_o,
    output logic [WQ_DEPTH-1:0]                ent_vld_o,
    output logic [WQ_DEPTH-1:0][PSIZE-1:0]     ent_addr_o
);

    localparam int PTR_W = $clog2(WQ_DEPTH);

    logic [WQ_DEPTH-1:0][PSIZE-1:0] addr_q;
    logic [WQ_DEPTH-1:0][WIDTH-1:0] data_q;
    logic [PTR_W-1:0]               wptr_q, wptr_d;
    logic [PTR_W-1:0]               rptr_q, rptr_d;
    logic [PTR_W:0]                 cnt_q, cnt_d;
    logic                           push_ok, pop_ok;

    assign full_o  = (cnt_q == (PTR_W+1)'(WQ_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        // Pointers wrap naturally: depth is a power of two.
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
        else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                addr_q[wptr_q] <= push_addr_i;
                data_q[wptr_q] <= push_data_i;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_addr_o = addr_q[rptr_q];
    assign head_data_o = data_q[rptr_q];
    assign ent_addr_o  = addr_q;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < WQ_DEPTH; i++) begin : g_vld
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(i) - rptr_q;
        assign ent_vld_o[i] = ({1'b0, off} < cnt_q);
    end

endmodule

// File: rtl/mem_req_sched.sv
// -----------------------------------------------------------------------------
// mem_req_sched
// Schedules queued writes and direct reads onto a single-port memory, one
// command per cycle. Reads never bypass a queued write to the same address:
// on a match the read is held off while writes drain. Otherwise write and
// read alternate round-robin, the last granted type losing a tie.
// Optional feature: define MEM_REQ_SCHED_STATS_EN to add saturating 16-bit
// counters hazard_stall_cnt, wr_issue_cnt and rd_issue_cnt.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   wr_valid/wr_ready, wr_addr,
//   wr_data                     : write request channel (queued)
//   rd_valid/rd_ready, rd_addr  : read request channel (issued directly)
//   in_wr, in_rd, in_wr_addr,
//   in_rd_addr, in_data         : memory command (fields zero when idle)
//   out_data                    : registered memory read data
//   rsp_valid, rsp_data         : read response, one cycle after in_rd
// -----------------------------------------------------------------------------
module mem_req_sched
    import mem_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PSIZE    = PSIZE_DEF,
    parameter int WQ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [PSIZE-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [PSIZE-1:0] rd_addr,
    output logic             in_wr,
    output logic             in_rd,
    output logic [PSIZE-1:0] in_wr_addr,
    output logic [PSIZE-1:0] in_rd_addr,
    output logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] out_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
`ifdef MEM_REQ_SCHED_STATS_EN
   ,output logic [15:0]      hazard_stall_cnt,
    output logic [15:0]      wr_issue_cnt,
    output logic [15:0]      rd_issue_cnt
`endif
);

    logic                           q_full, q_empty;
    logic [PSIZE-1:0]               head_addr;
    logic [WIDTH-1:0]               head_data;
    logic [WQ_DEPTH-1:0]            ent_vld;
    logic [WQ_DEPTH-1:0][PSIZE-1:0] ent_addr;

    logic  live_q;          // low in reset and the first cycle after release
    gnt_e  last_q, last_d;  // last granted type for round-robin
    gnt_e  gnt;
    logic  rsp_vld_q;
    logic  hazard, wr_elig, rd_elig, push;

    mem_wr_fifo #(
        .WIDTH    (WIDTH),
        .PSIZE    (PSIZE),
        .WQ_DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_addr_i (wr_addr),
        .push_data_i (wr_data),
        .pop_i       (in_wr),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .ent_vld_o   (ent_vld),
        .ent_addr_o  (ent_addr)
    );

    // Read-after-write hazard against any queued write.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == rd_addr)) hazard = 1'b1;
        end
    end

    assign wr_elig = !q_empty;
    assign rd_elig = rd_valid && !hazard;

    always_comb begin
        gnt = GNT_NONE;
        if (live_q) begin
            if (wr_elig && rd_elig) gnt = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
            else if (wr_elig)       gnt = GNT_WR;
            else if (rd_elig)       gnt = GNT_RD;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt != GNT_NONE) last_d = gnt;
    end

    assign wr_ready   = live_q && !q_full;
    assign push       = wr_valid && wr_ready;
    assign rd_ready   = (gnt == GNT_RD);
    assign in_rd      = rd_valid && rd_ready;
    assign in_wr      = (gnt == GNT_WR);
    assign in_wr_addr = in_wr ? head_addr : '0;
    assign in_data    = in_wr ? head_data : '0;
    assign in_rd_addr = in_rd ? rd_addr   : '0;
    assign rsp_valid  = rsp_vld_q;
    assign rsp_data   = rsp_vld_q ? out_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            last_q    <= GNT_WR;    // read wins the first tie
            rsp_vld_q <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            last_q    <= last_d;
            rsp_vld_q <= in_rd;
        end
    end

`ifdef MEM_REQ_SCHED_STATS_EN
    logic [STAT_W-1:0] haz_cnt_q, wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haz_cnt_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            haz_cnt_q <= sat_inc(haz_cnt_q, live_q && rd_valid && hazard);
            wr_cnt_q  <= sat_inc(wr_cnt_q, in_wr);
            rd_cnt_q  <= sat_inc(rd_cnt_q, in_rd);
        end
    end

    assign hazard_stall_cnt = haz_cnt_q;
    assign wr_issue_cnt     = wr_cnt_q;
    assign rd_issue_cnt     = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched with a small registered memory model.
module tb_mem_req_sched;
    localparam int WIDTH = 2;
    localparam int PSIZE = 2;
    localparam int WQ_DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0, rd_valid = 1'b0;
    logic [PSIZE-1:0] wr_addr = '0, rd_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ready, rd_ready, in_wr, in_rd, rsp_valid;
    logic [PSIZE-1:0] in_wr_addr, in_rd_addr;
    logic [WIDTH-1:0] in_data, rsp_data;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] mem [2**PSIZE];
`ifdef MEM_REQ_SCHED_STATS_EN
    logic [15:0] hazard_stall_cnt, wr_issue_cnt, rd_issue_cnt;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_req_sched #(.WIDTH(WIDTH), .PSIZE(PSIZE), .WQ_DEPTH(WQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .in_wr(in_wr), .in_rd(in_rd), .in_wr_addr(in_wr_addr), .in_rd_addr(in_rd_addr),
        .in_data(in_data), .out_data(out_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef MEM_REQ_SCHED_STATS_EN
       ,.hazard_stall_cnt(hazard_stall_cnt), .wr_issue_cnt(wr_issue_cnt), .rd_issue_cnt(rd_issue_cnt)
`endif
    );

    // Memory model: registered read data, cleared while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**PSIZE; i++) mem[i] <= '0;
            out_data <= '0;
        end else begin
            if (in_wr) mem[in_wr_addr] <= in_data;
            if (in_rd) out_data <= mem[in_rd_addr];
        end
    end

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 2'd3; rd_valid = 1'b1; rd_addr = 2'd1;
        #1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rst_wr_ready: got %0b exp 0", wr_ready); end
        tests++; if (rd_ready !== 1'b0) begin fails++; $display("FAIL rst_rd_ready: got %0b exp 0", rd_ready); end
        tests++; if (in_rd !== 1'b0) begin fails++; $display("FAIL rst_in_rd: got %0b exp 0", in_rd); end
        tests++; if (in_wr !== 1'b0) begin fails++; $display("FAIL rst_in_wr: got %0b exp 0", in_wr); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %0b exp 0", rsp_valid); end
        tests++; if ({in_wr_addr, in_rd_addr, in_data, rsp_data} !== 8'h00) begin fails++; $display("FAIL rst_fields: got %0h exp 0", {in_wr_addr, in_rd_addr, in_data, rsp_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (in_rd !== 1'b0) begin fails++; $display("FAIL post_rst_in_rd: got %0b exp 0", in_rd); end
        tests++; if (rd_ready !== 1'b0) begin fails++; $display("FAIL post_rst_rd_ready: got %0b exp 0", rd_ready); end
        tests++; if (in_rd_addr !== 2'd0) begin fails++; $display("FAIL post_rst_rd_addr: got %0d exp 0", in_rd_addr); end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic test_hazard;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 2'd1;
        #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL haz_wr_ready: got %0b exp 1", wr_ready); end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 2'd1;
        #1;
        tests++; if (rd_ready !== 1'b0) begin fails++; $display("FAIL haz_stall_rd_ready: got %0b exp 0", rd_ready); end
        tests++; if ({in_wr, in_rd} !== 2'b10) begin fails++; $display("FAIL haz_stall_cmds: got %b exp 10", {in_wr, in_rd}); end
        tests++; if ({in_wr_addr, in_data} !== {2'd1, 2'd1}) begin fails++; $display("FAIL haz_wr_fields: got %0h exp 5", {in_wr_addr, in_data}); end
        @(negedge clk);
        #1;
        tests++; if ({rd_ready, in_rd, in_wr} !== 3'b110) begin fails++; $display("FAIL haz_read_grant: got %b exp 110", {rd_ready, in_rd, in_wr}); end
        tests++; if (in_rd_addr !== 2'd1) begin fails++; $display("FAIL haz_rd_addr: got %0d exp 1", in_rd_addr); end
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL haz_rsp_valid: got %0b exp 1", rsp_valid); end
        tests++; if (rsp_data !== 2'd1) begin fails++; $display("FAIL haz_rsp_data: got %0d exp 1", rsp_data); end
        @(negedge clk);
        #1;
        tests++; if ({rsp_valid, rsp_data} !== 3'b000) begin fails++; $display("FAIL haz_rsp_idle: got %b exp 000", {rsp_valid, rsp_data}); end
    endtask

    task automatic test_full;
        // Lone write first so the round-robin pointer sits on write.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 2'd3;
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        tests++; if ({in_wr, in_wr_addr, in_data} !== 5'b1_00_11) begin fails++; $display("FAIL full_pre_wr: got %b exp 10011", {in_wr, in_wr_addr, in_data}); end
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 2'd2;
        #1;
        tests++; if ({wr_ready, in_wr} !== 2'b10) begin fails++; $display("FAIL full_push1: got %b exp 10", {wr_ready, in_wr}); end
        @(negedge clk);
        wr_addr = 2'd3; wr_data = 2'd3; rd_valid = 1'b1; rd_addr = 2'd0;
        #1;
        tests++; if ({wr_ready, in_rd, in_wr} !== 3'b110) begin fails++; $display("FAIL full_push2: got %b exp 110", {wr_ready, in_rd, in_wr}); end
        @(negedge clk);
        wr_addr = 2'd1; wr_data = 2'd1; rd_valid = 1'b0;
        #1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL full_third_ready: got %0b exp 0", wr_ready); end
        tests++; if ({in_wr, in_wr_addr, in_data} !== 5'b1_10_10) begin fails++; $display("FAIL full_drain1: got %b exp 11010", {in_wr, in_wr_addr, in_data}); end
        tests++; if ({rsp_valid, rsp_data} !== 3'b111) begin fails++; $display("FAIL full_rsp: got %b exp 111", {rsp_valid, rsp_data}); end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        tests++; if ({in_wr, in_wr_addr, in_data} !== 5'b1_11_11) begin fails++; $display("FAIL full_drain2: got %b exp 11111", {in_wr, in_wr_addr, in_data}); end
        @(negedge clk);
        #1;
        tests++; if (in_wr !== 1'b0) begin fails++; $display("FAIL full_empty: got %0b exp 0", in_wr); end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10; // {in_wr,in_rd}
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 2'd1;
        @(negedge clk);
        wr_addr = 2'd3; wr_data = 2'd2; rd_valid = 1'b1; rd_addr = 2'd1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                wr_valid = 1'b0;
            end
            #1;
            tests++; if ({in_wr, in_rd} !== exp_seq[k]) begin fails++; $display("FAIL alt_grant%0d: got %b exp %b", k, {in_wr, in_rd}, exp_seq[k]); end
            tests++; if (in_wr && in_rd) begin fails++; $display("FAIL alt_both%0d: got in_wr=1 in_rd=1 exp not both", k); end
            if (k == 1) begin
                tests++; if ({in_wr_addr, rsp_valid, rsp_data} !== 5'b10_1_01) begin fails++; $display("FAIL alt_wr_rsp: got %b exp 10101", {in_wr_addr, rsp_valid, rsp_data}); end
            end
        end
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 2'd2;
        @(negedge clk);
        wr_addr = 2'd1; wr_data = 2'd3; rd_valid = 1'b1; rd_addr = 2'd2;
        #1;
        tests++; if (in_rd !== 1'b1) begin fails++; $display("FAIL mid_read_issue: got %0b exp 1", in_rd); end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        tests++; if ({rsp_valid, in_wr} !== 2'b11) begin fails++; $display("FAIL mid_pre_reset: got %b exp 11", {rsp_valid, in_wr}); end
        rst_n = 1'b0;
        #1;
        tests++; if ({rsp_valid, in_wr, in_rd, wr_ready, rd_ready} !== 5'b0) begin fails++; $display("FAIL mid_async_strobes: got %b exp 00000", {rsp_valid, in_wr, in_rd, wr_ready, rd_ready}); end
        tests++; if ({in_wr_addr, in_data, in_rd_addr, rsp_data} !== 8'h00) begin fails++; $display("FAIL mid_async_fields: got %0h exp 0", {in_wr_addr, in_data, in_rd_addr, rsp_data}); end
        @(negedge clk);
        rst_n = 1'b1; rd_valid = 1'b0;
        #1;
        tests++; if ({rsp_valid, in_wr} !== 2'b00) begin fails++; $display("FAIL mid_release: got %b exp 00", {rsp_valid, in_wr}); end
        @(negedge clk);
        #1;
        tests++; if ({rsp_valid, in_wr, wr_ready} !== 3'b001) begin fails++; $display("FAIL mid_queue_flushed: got %b exp 001", {rsp_valid, in_wr, wr_ready}); end
    endtask

    task automatic test_stall_stats;
`ifdef MEM_REQ_SCHED_STATS_EN
        #1;
        tests++; if (hazard_stall_cnt !== 16'd0) begin fails++; $display("FAIL stats_reset: got %0d exp 0", hazard_stall_cnt); end
`endif
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 2'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_valid = 1'b1; rd_addr = 2'd1; wr_data = 2'(k + 2);
            if (k == 2) wr_valid = 1'b0;
            #1;
            tests++; if ({rd_ready, in_wr} !== 2'b01) begin fails++; $display("FAIL stall%0d: got %b exp 01", k, {rd_ready, in_wr}); end
        end
        @(negedge clk);
        #1;
        tests++; if (in_rd !== 1'b1) begin fails++; $display("FAIL stall_release: got %0b exp 1", in_rd); end
        @(negedge clk);
        rd_valid = 1'b0;
`ifdef MEM_REQ_SCHED_STATS_EN
        #1;
        tests++; if (hazard_stall_cnt !== 16'd3) begin fails++; $display("FAIL stats_hazard: got %0d exp 3", hazard_stall_cnt); end
        tests++; if (wr_issue_cnt !== 16'd3) begin fails++; $display("FAIL stats_wr: got %0d exp 3", wr_issue_cnt); end
        tests++; if (rd_issue_cnt !== 16'd1) begin fails++; $display("FAIL stats_rd: got %0d exp 1", rd_issue_cnt); end
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hazard();
        test_full();
        test_alternate();
        test_reset_mid();
        test_stall_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
